fft_ibutterfly_pipe: RTL and testbench

- Inverse radix-2 butterfly. From a DIT butterfly's outputs (sum = A+B·W, diff = A−B·W) and the same twiddle W, recovers A = (sum+diff)/2 and B = (sum−diff)·conj(W)/2.
- 3-stage pipeline with valid/ready handshake on both sides; backpressure propagates to the input.
- Sits in the IFFT path and in the round-trip self-check next to the forward butterflies.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_cmul_conj.sv | 47 ++++
 rtl/fft_ibutterfly_pipe.sv | 140 ++++++++++++++
 tb/tb_fft_ibutterfly_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default packed-complex geometry, reference
// twiddles and a range helper for the inverse butterfly.
//   WIDTH  : packed complex width {Re, Im}
//   HALF   : component width (Q1.15 at the default WIDTH)
//   PROD_W : width of a complex-multiply accumulator
//   W0, W1 : twiddles 1 (0x7FFF + 0j) and -j (0 + 0x8000j)
package fft_pkg;

  localparam int WIDTH  = 32;
  localparam int HALF   = WIDTH / 2;
  localparam int PROD_W = 2 * HALF + 2;

  localparam logic [WIDTH-1:0] W0 = 32'h7FFF_0000;
  localparam logic [WIDTH-1:0] W1 = 32'h0000_8000;

  typedef struct packed {
    logic signed [HALF-1:0] re;
    logic signed [HALF-1:0] im;
  } cplx_t;

  // A HALF+2 bit value fits in HALF bits only when its top three bits
  // agree, so the check is independent of the component width.
  function automatic logic b_out_of_range(input logic [2:0] top3);
    return !(top3 == 3'b000 || top3 == 3'b111);
  endfunction

endpackage

// File: rtl/fft_cmul_conj.sv
// Registered multiply by the conjugate twiddle, m = d * conj(w), computed
// by formula so w_im is never negated (w_im = most-negative stays exact).
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : pipeline advance; outputs hold while low
//   d_re, d_im   : HALF+1 bit signed difference
//   w_re, w_im   : HALF bit signed twiddle
//   m_re, m_im   : 2*HALF+2 bit signed products, registered
module fft_cmul_conj #(
  parameter int HALF = 16,
  localparam int PW  = 2 * HALF + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [HALF:0] d_re,
  input  logic signed [HALF:0] d_im,
  input  logic signed [HALF-1:0] w_re,
  input  logic signed [HALF-1:0] w_im,
  output logic signed [PW-1:0] m_re,
  output logic signed [PW-1:0] m_im
);

  logic signed [PW-1:0] dre_x, dim_x, wre_x, wim_x;
  logic signed [PW-1:0] m_re_n, m_im_n;

  // Operands widened to the accumulator width; the true products need
  // only 2*HALF+1 bits, so the PW-bit products are exact.
  always_comb begin
    dre_x  = {{(PW-HALF-1){d_re[HALF]}}, d_re};
    dim_x  = {{(PW-HALF-1){d_im[HALF]}}, d_im};
    wre_x  = {{(PW-HALF){w_re[HALF-1]}}, w_re};
    wim_x  = {{(PW-HALF){w_im[HALF-1]}}, w_im};
    m_re_n = dre_x * wre_x + dim_x * wim_x;
    m_im_n = dim_x * wre_x - dre_x * wim_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_re <= '0;
      m_im <= '0;
    end else if (en) begin
      m_re <= m_re_n;
      m_im <= m_im_n;
    end
  end

endmodule

// File: rtl/fft_ibutterfly_pipe.sv
// Inverse radix-2 butterfly, 3-stage stall-all pipeline.
// Recovers A = (sum+diff)/2 and B = (sum-diff)*conj(W)/2.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready = !out_valid || out_ready)
//   in_sum, in_diff     : packed {Re, Im} forward butterfly outputs
//   in_w                : packed twiddle used by the forward butterfly
//   out_valid/out_ready : output handshake
//   out_a, out_b        : recovered A and B, packed
//   out_ovf             : a B component fell outside the HALF-bit range
// Build option FFT_IBFLY_SAT_EN: out-of-range B components saturate;
// otherwise they wrap to the low HALF bits. out_ovf flags both cases.
module fft_ibutterfly_pipe #(
  parameter int WIDTH = 32,
  localparam int HALF = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_diff,
  input  logic [WIDTH-1:0] in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_ovf
);

  import fft_pkg::*;

  localparam int PW = 2 * HALF + 2;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: component sum/difference, one guard bit
  logic signed [HALF:0] sum_re_x, sum_im_x, diff_re_x, diff_im_x;
  logic signed [HALF:0] p_re_n, p_im_n, d_re_n, d_im_n;

  always_comb begin
    sum_re_x  = {in_sum[WIDTH-1], in_sum[WIDTH-1:HALF]};
    sum_im_x  = {in_sum[HALF-1], in_sum[HALF-1:0]};
    diff_re_x = {in_diff[WIDTH-1], in_diff[WIDTH-1:HALF]};
    diff_im_x = {in_diff[HALF-1], in_diff[HALF-1:0]};
    p_re_n    = sum_re_x + diff_re_x;
    p_im_n    = sum_im_x + diff_im_x;
    d_re_n    = sum_re_x - diff_re_x;
    d_im_n    = sum_im_x - diff_im_x;
  end

  logic                 s1_valid;
  logic signed [HALF:0] s1_p_re, s1_p_im, s1_d_re, s1_d_im;
  logic [WIDTH-1:0]     s1_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p_re  <= '0;
      s1_p_im  <= '0;
      s1_d_re  <= '0;
      s1_d_im  <= '0;
      s1_w     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_p_re  <= p_re_n;
      s1_p_im  <= p_im_n;
      s1_d_re  <= d_re_n;
      s1_d_im  <= d_im_n;
      s1_w     <= in_w;
    end
  end

  // Stage 2: conj multiply in the sub-module, p carried alongside
  logic                 s2_valid;
  logic signed [HALF:0] s2_p_re, s2_p_im;
  logic signed [PW-1:0] s2_m_re, s2_m_im;

  fft_cmul_conj #(.HALF(HALF)) u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (adv),
    .d_re (s1_d_re),
    .d_im (s1_d_im),
    .w_re (s1_w[WIDTH-1:HALF]),
    .w_im (s1_w[HALF-1:0]),
    .m_re (s2_m_re),
    .m_im (s2_m_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_p_re  <= '0;
      s2_p_im  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_p_re  <= s1_p_re;
      s2_p_im  <= s1_p_im;
    end
  end

  // Stage 3: >>>1 on p is its top HALF bits; >>>HALF on m keeps HALF+2 bits
  logic [HALF+1:0] kept_re, kept_im;
  logic            ovf_re, ovf_im;
  logic [HALF-1:0] b_re, b_im;

  always_comb begin
    kept_re = s2_m_re[PW-1:HALF];
    kept_im = s2_m_im[PW-1:HALF];
    ovf_re  = b_out_of_range(kept_re[HALF+1:HALF-1]);
    ovf_im  = b_out_of_range(kept_im[HALF+1:HALF-1]);
    b_re    = kept_re[HALF-1:0];
    b_im    = kept_im[HALF-1:0];
`ifdef FFT_IBFLY_SAT_EN
    if (ovf_re) b_re = kept_re[HALF+1] ? {1'b1, {(HALF-1){1'b0}}} : {1'b0, {(HALF-1){1'b1}}};
    if (ovf_im) b_im = kept_im[HALF+1] ? {1'b1, {(HALF-1){1'b0}}} : {1'b0, {(HALF-1){1'b1}}};
`endif
  end

  // Fraction bits dropped by the shifts
  logic unused_frac;
  assign unused_frac = ^{s2_m_re[HALF-1:0], s2_m_im[HALF-1:0], s2_p_re[0], s2_p_im[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_a     <= {s2_p_re[HALF:1], s2_p_im[HALF:1]};
      out_b     <= {b_re, b_im};
      out_ovf   <= ovf_re | ovf_im;
    end
  end

endmodule

// File: tb/tb_fft_ibutterfly_pipe.sv
// Scoreboard bench for fft_ibutterfly_pipe: golden model computes expected
// outputs at accept time; the monitor pops and compares at output transfer.
module tb_fft_ibutterfly_pipe;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum, in_diff, in_w;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic        out_ovf;

  always #5 clk = ~clk;

  fft_ibutterfly_pipe #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_diff  (in_diff),
    .in_w     (in_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_ovf  (out_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf;
    logic        has_orig;
    logic [31:0] oa;
    logic [31:0] ob;
    logic        chk_lat;
    int unsigned acc_cyc;
  } sb_t;

  sb_t sb_q[$];

  int unsigned pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  function automatic logic [64:0] golden(input logic [31:0] s, input logic [31:0] d,
                                         input logic [31:0] w);
    longint sr, si, dr, di, wr, wi, pr, pi, qr, qi, mr, mi, ar, ai, br, bi;
    logic [15:0] bro, bio;
    logic        ovr, ovi;
    sr = longint'($signed(s[31:16]));
    si = longint'($signed(s[15:0]));
    dr = longint'($signed(d[31:16]));
    di = longint'($signed(d[15:0]));
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    pr = sr + dr; pi = si + di;
    qr = sr - dr; qi = si - di;
    ar = pr >>> 1; ai = pi >>> 1;
    mr = qr * wr + qi * wi;
    mi = qi * wr - qr * wi;
    br = mr >>> 16; bi = mi >>> 16;
    ovr = (br > 32767) || (br < -32768);
    ovi = (bi > 32767) || (bi < -32768);
    bro = br[15:0];
    bio = bi[15:0];
`ifdef FFT_IBFLY_SAT_EN
    if (ovr) bro = (br > 0) ? 16'h7FFF : 16'h8000;
    if (ovi) bio = (bi > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {ovr | ovi, ar[15:0], ai[15:0], bro, bio};
  endfunction

  // Forward DIT butterfly with Q15 twiddle product: {sum, diff}
  function automatic logic [63:0] fwd(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] w);
    longint ar, ai, br, bi, wr, wi, tr, ti, sr, si, dr, di;
    logic [31:0] s, d;
    ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
    tr = (br * wr - bi * wi) >>> 15;
    ti = (br * wi + bi * wr) >>> 15;
    sr = ar + tr; si = ai + ti;
    dr = ar - tr; di = ai - ti;
    s = {sr[15:0], si[15:0]};
    d = {dr[15:0], di[15:0]};
    return {s, d};
  endfunction

  function automatic logic near(input logic [31:0] got, input logic [31:0] want, input int tol);
    int er, ei;
    er = int'($signed(got[31:16])) - int'($signed(want[31:16]));
    ei = int'($signed(got[15:0])) - int'($signed(want[15:0]));
    return (er <= tol) && (er >= -tol) && (ei <= tol) && (ei >= -tol);
  endfunction

  task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [31:0] w,
                      input logic ho, input logic [31:0] oa, input logic [31:0] ob,
                      input logic cl);
    sb_t e;
    logic [64:0] g;
    g = golden(s, d, w);
    e.ovf = g[64]; e.a = g[63:32]; e.b = g[31:0];
    e.has_orig = ho; e.oa = oa; e.ob = ob; e.chk_lat = cl; e.acc_cyc = 0;
    in_sum = s; in_diff = d; in_w = w; in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc_cyc = pcyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check_val("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_rt(input logic [31:0] w, input logic cl);
    logic [31:0] a, b;
    logic [63:0] sd;
    int ar, ai, br, bi;
    ar = int'($urandom_range(0, 32766)) - 16383;
    ai = int'($urandom_range(0, 32766)) - 16383;
    br = int'($urandom_range(0, 32766)) - 16383;
    bi = int'($urandom_range(0, 32766)) - 16383;
    a = {ar[15:0], ai[15:0]};
    b = {br[15:0], bi[15:0]};
    sd = fwd(a, b, w);
    send(sd[63:32], sd[31:0], w, 1'b1, a, b, cl);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb_q.size() != 0; t++) @(posedge clk);
    check_val("drain_empty", 96'(sb_q.size()), 0);
    #1;
  endtask

  // out_ready pattern: 0 = held high, 1 = toggling 1010...
  int rdy_mode = 0;
  always begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  // Monitor
  logic        prev_stall = 1'b0;
  logic [64:0] prev_data;
  sb_t         mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check_val("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", {out_a, out_b, out_ovf}, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_out", out_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("out_a", out_a, mon_e.a);
          check_val("out_b", out_b, mon_e.b);
          check_val("out_ovf", out_ovf, mon_e.ovf);
          if (mon_e.has_orig) begin
            check_val("rt_a_1lsb", near(out_a, mon_e.oa, 1), 1);
            check_val("rt_b_2lsb", near(out_b, mon_e.ob, 2), 1);
          end
          if (mon_e.chk_lat) check_val("latency", 96'(pcyc - mon_e.acc_cyc), 3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = {out_a, out_b, out_ovf};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_diff = '0; in_w = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", {out_a, out_b, out_ovf}, 0);
    check_val("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed beats, each isolated so latency is measured
    send(32'h4000_0000, 32'h2000_0000, W0, 1'b0, '0, '0, 1'b1);
    drain();
    send(32'h0000_1000, 32'hF000_0000, W1, 1'b0, '0, '0, 1'b1);
    drain();
    send(32'h7FFF_7FFF, 32'h8000_8000, 32'h7FFF_7FFF, 1'b0, '0, '0, 1'b1);
    drain();
    send(32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_8000, 1'b0, '0, '0, 1'b1);
    drain();

    // Round trip, back to back
    for (int i = 0; i < 16; i++) send_rt((i % 2 == 0) ? W0 : W1, 1'b0);
    drain();

    // Backpressure with toggling out_ready and random input gaps
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_rt((i % 3 == 0) ? W1 : W0, 1'b0);
    end
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) send_rt(W0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_out_data", {out_a, out_b, out_ovf}, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send_rt(W1, 1'b1);
    drain();

    check_val("final_sb_empty", 96'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
